// File: rtl/rs_pkg.sv
// Shared RS(15,9) GF(16) constants and the decode scheduler state type.
package rs_pkg;

    localparam int RS_N    = 15;
    localparam int RS_K    = 9;
    localparam int SYM_W   = 4;
    localparam int WORD_W  = RS_N * SYM_W;
    localparam int MSG_W   = RS_K * SYM_W;
    localparam int MSG_LSB = (RS_N - RS_K) * SYM_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } sched_state_t;

endpackage

// File: rtl/rs_rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping modulo N_REQ.
module rs_rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant
);

    logic found;

    // Offset k walks ptr+1, ptr+2, ... so the last winner has lowest priority.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int r = 0; r < N_REQ; r++) begin
                if (!found && req[r] && (r == ((int'(ptr) + k) % N_REQ))) begin
                    grant[r] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rs_decode_sched.sv
// Shares one RS(15,9) decoder between N_REQ requesters: round-robin grant,
// toggle-launched decode, settle plus busy wait with timeout, valid/ready result.
module rs_decode_sched
    import rs_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int DEC_LAT = 2,
    parameter int TIMEOUT = 15,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*WORD_W-1:0] req_word,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [MSG_W-1:0]        rsp_msg,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_timeout,
    output logic [WORD_W-1:0]       dec_word,
    output logic                    dec_start,
    input  logic                    dec_busy,
    input  logic [MSG_W-1:0]        dec_msg
);

    localparam int CNT_W = (DEC_LAT > 0) ? $clog2(DEC_LAT + 1) : 1;
    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    sched_state_t      state;
    sched_state_t      stateNext;
    logic [ID_W-1:0]   ptr;
    logic [CNT_W-1:0]  cnt;
    logic [TMO_W-1:0]  tmo;
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grantIdx;
    logic [WORD_W-1:0] selWord;
    logic              accept;
    logic              tmoDone;
    logic              capture;

    rs_rr_arbiter #(
        .N_REQ(N_REQ),
        .ID_W (ID_W)
    ) arbiter (
        .req  (req_valid),
        .ptr  (ptr),
        .grant(grant)
    );

    always_comb begin
        grantIdx = '0;
        selWord  = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (grant[r]) begin
                grantIdx = ID_W'(r);
                selWord  = req_word[r*WORD_W +: WORD_W];
            end
        end
    end

    assign req_ready = (rst_n && state == IDLE) ? grant : '0;
    assign rsp_valid = (state == RESP);
    assign accept    = (state == IDLE) && (|grant);
    // Forced capture happens one cycle after tmo reaches TIMEOUT with busy still high.
    assign tmoDone   = (tmo == TMO_W'(TIMEOUT));
    assign capture   = (state == WAIT) && (cnt == '0) && (!dec_busy || tmoDone);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept)    stateNext = WAIT;
            WAIT:    if (capture)   stateNext = RESP;
            RESP:    if (rsp_ready) stateNext = IDLE;
            default:                stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= ID_W'(N_REQ - 1);
            cnt         <= '0;
            tmo         <= '0;
            dec_start   <= 1'b0;
            dec_word    <= '0;
            rsp_msg     <= '0;
            rsp_id      <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state <= stateNext;
            if (accept) begin
                dec_word  <= selWord;
                rsp_id    <= grantIdx;
                dec_start <= ~dec_start;
                ptr       <= grantIdx;
                cnt       <= CNT_W'(DEC_LAT);
                tmo       <= '0;
            end
            if (state == WAIT) begin
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end else if (capture) begin
                    rsp_msg     <= dec_msg;
                    rsp_timeout <= dec_busy;
                end else begin
                    tmo <= tmo + TMO_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/rs_decode_sched.md
# rs_decode_sched

Clocked scheduler that shares one RS(15,9) GF(16) decoder instance between `N_REQ` requesters. It:
- arbitrates incoming 60-bit received words round-robin;
- launches the decoder by toggling its start line;
- waits a fixed settle time plus busy-release;
- returns the 36-bit message with the originating requester ID over a valid/ready response channel.

It sits between the link-side frame buffers and the decoder, and is the only block that drives the decoder's inputs.

## Interface
Parameters:
- `N_REQ`, 2, number of requesters (2..8)
- `DEC_LAT`, 2, settle cycles after start toggle before the result is sampled (≥1)
- `TIMEOUT`, 15, extra cycles allowed for `dec_busy` to fall before a forced capture

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset: synchronous, active-low
- `req_valid`  in  N_REQ  per-requester word valid
- `req_word`  in  N_REQ*60  per-requester received word; slice r = `[60r +: 60]`, symbol i at `[4i +: 4]`
- `req_ready`  out  N_REQ  one-hot grant/accept
- `rsp_valid`  out  1  result valid
- `rsp_ready`  in  1  result accepted
- `rsp_msg`  out  36  decoded message symbols 6..14
- `rsp_id`  out  ID_W  requester index, ID_W = max(1,$clog2(N_REQ))
- `rsp_timeout`  out  1  result captured by timeout, not by busy release
- `dec_word`  out  60  to decoder received-word input
- `dec_start`  out  1  to decoder start; each level change launches one decode
- `dec_busy`  in  1  from decoder
- `dec_msg`  in  36  from decoder message output

## Operation
States: IDLE, WAIT, RESP.

**IDLE**
- `req_ready[g]`=1 combinationally for at most one g. g is the first requester with `req_valid` set, searching from `ptr`+1 modulo N_REQ.
- On handshake:
  - latch `req_word` slice into `dec_word` and g into `rsp_id`;
  - invert `dec_start`;
  - `ptr`←g; `cnt`←DEC_LAT; go to WAIT.

**WAIT** (`req_ready`=0)
- While `cnt`≠0: decrement.
- When `cnt`=0 and `dec_busy`=0:
  - `rsp_msg`←`dec_msg`, `rsp_timeout`←0;
  - go to RESP.
- When `cnt`=0 and `dec_busy`=1: increment timeout counter `tmo`.
  - When `tmo` reaches TIMEOUT: `rsp_msg`←`dec_msg`, `rsp_timeout`←1, go to RESP.
  - `tmo` clears on entering WAIT.

**RESP**
- `rsp_valid`=1; `rsp_msg`, `rsp_id`, `rsp_timeout` stable until accepted.
- On `rsp_valid`&&`rsp_ready`: go to IDLE.

General rules:
- `dec_word` holds its value until the next grant.
- `dec_start` changes only on a grant edge.
- No new request is accepted until the response is taken; exactly one decode is in flight.
- `req_valid` deassertion in WAIT or RESP has no effect; the in-flight word is already latched.

Reset (`rst_n`=0 at a clock edge) values:
- state=IDLE, `ptr`=N_REQ-1 (requester 0 has first priority);
- `cnt`=0, `tmo`=0;
- `dec_start`=0, `dec_word`=0;
- `rsp_valid`=0, `rsp_msg`=0, `rsp_id`=0, `rsp_timeout`=0;
- `req_ready`=0 while reset is asserted.

Reset mid-operation discards the in-flight decode without a response. If `dec_start` was 1, its return to 0 launches a spurious decode of all-zero `dec_word`; that result is ignored.

## Timing
- Grant at edge E0: `dec_start` toggles after E0.
- With `dec_busy` low at sample time, `rsp_valid` rises after edge E0+DEC_LAT+1. Default: 3 cycles.
- Each cycle `dec_busy` stays high after `cnt`=0 adds one cycle, up to TIMEOUT.
- If `rsp_ready` is held high, RESP lasts 1 cycle; the next grant occurs in the following IDLE cycle.
- Minimum grant-to-grant spacing: DEC_LAT+3 cycles. Default: 5.
- Requests are fair: with all N_REQ valid, each requester is granted once per N_REQ grants.

## Structure
- Shared package `rs_pkg`:
  - `RS_N`=15, `RS_K`=9, `SYM_W`=4, `WORD_W`=60, `MSG_W`=36;
  - state enum `sched_state_t` {IDLE, WAIT, RESP}.
- One sub-module, `rs_rr_arbiter`: N_REQ-wide round-robin pick. Inputs: request vector, `ptr`. Output: one-hot grant. Purely combinational.
- FSM, counters and datapath registers live in `rs_decode_sched`.

## Test plan
1. **Clean word.** Reset, then requester 0 sends all-zero word. Expect `rsp_valid` 3 cycles after grant, `rsp_msg`=36'h0, `rsp_id`=0, `rsp_timeout`=0, `dec_start` toggled once.
2. **Single-error correction.** Requester 1 sends all-zero word with symbol 3 = 4'h5 (`req_word[15:12]`). Expect `rsp_msg`=0, `rsp_id`=1. With `rsp_ready` held 0 for 4 cycles, outputs stay stable and `req_ready` stays 0.
3. **Round-robin fairness.** N_REQ=2, both requesters continuously valid, `rsp_ready`=1, 6 decodes. Expect grant order 0,1,0,1,0,1 and grant spacing exactly 5 cycles.
4. **Busy extension and timeout.** Hold `dec_busy` high 3 cycles past `cnt`=0: capture 3 cycles late, `rsp_timeout`=0. Hold it high 20 cycles: capture at TIMEOUT=15, `rsp_timeout`=1.
5. **Reset in WAIT.** Drop `rst_n` one cycle after a grant. Expect no `rsp_valid`, all outputs at reset values, `ptr` reset so requester 0 is granted first afterwards.
